led_matrix_scanner: RTL and testbench
=====================================

# led_matrix_scanner

Time-multiplexed driver for the CPLD kit's 5×7 LED matrix, directly downstream of the irrigation image decoders. It takes the three Y-symmetric half-image columns (`col_2`, `col_1`, `col_0`), mirrors them to five physical columns, and scans one column at a time with anti-ghosting blanking. The input image is latched only at frame boundaries, so the display never tears, and an optional frame-synchronous blink is provided.

## Interface
- `CLK_DIV`, 50000: clock cycles per column slot; must be ≥ 2.
- `BLANK`, 2: leading cycles of each slot with all columns off; must satisfy 1 ≤ BLANK < CLK_DIV.
- `BLINK_FRAMES`, 100: frames per blink half-period; must be ≥ 1.
- `clk`  in  1: system clock.
- `reset_n`  in  1: synchronous, active-low reset.
- `col_2`  in  7: row pattern for physical columns 0 and 4; bit r drives row r.
- `col_1`  in  7: row pattern for physical columns 1 and 3.
- `col_0`  in  7: row pattern for physical column 2.
- `blink_en`  in  1: enables periodic blanking of the whole image.
- `matrix_cols`  out  5: column select, active-low, one-hot-low when a column is lit.
- `matrix_rows`  out  7: row data, active-high.
- `frame_start`  out  1: single-cycle pulse on the first cycle of column 0's slot.

## Operation
- Prescaler `div` counts 0..CLK_DIV-1 and wraps. When `div == CLK_DIV-1`, the column index `col_idx` advances 0→1→2→3→4→0.
- Shadow image: the 7-bit registers `sh2`, `sh1`, `sh0` load `col_2`, `col_1`, `col_0` on the cycle where `col_idx` wraps 4→0. Between wraps, input changes have no effect on the display.
- Mirror map: column 0 and column 4 use `sh2`, column 1 and column 3 use `sh1`, column 2 uses `sh0`.
- Slot phases, decided by `div`:
  - BLANK phase (`div < BLANK`): `matrix_cols = 5'b11111` and `matrix_rows = 0`.
  - DRIVE phase (`div ≥ BLANK`): `matrix_cols[col_idx] = 0` and all other bits are 1. `matrix_rows` carries the mirrored shadow column, ANDed with `blink_on`.
- Blink: `bcnt` counts completed frames (one count per 4→0 wrap). At `bcnt == BLINK_FRAMES-1` it wraps to 0 and `blink_on` toggles.
  - While `blink_en = 0`, `bcnt` is held at 0 and `blink_on` at 1.
  - When `blink_en` rises, counting starts from 0 with the image on.
- `frame_start` is high for exactly one cycle per frame, on the cycle where `col_idx == 0` and `div == 0` (registered).
- Reset values: `div = 0`, `col_idx = 0`, shadow registers = 0, `bcnt = 0`, `blink_on = 1`, `matrix_cols = 5'b11111`, `matrix_rows = 0`, `frame_start = 0`.

## Timing
- All outputs are registered and derived from the state of the previous cycle, so each output lags the state it reflects by 1 cycle.
- Column slot length is CLK_DIV cycles and frame length is 5·CLK_DIV cycles. Lit time per slot is CLK_DIV−BLANK cycles.
- Image latency: an input change appears from the next frame boundary, at worst about 5·CLK_DIV+1 cycles later.
- Simultaneous events:
  - A 4→0 wrap that coincides with the blink wrap updates the shadow image and `blink_on` together, so the new frame starts with both updates applied.
  - If `blink_en` falls mid-frame, `blink_on` is forced to 1 on the next cycle and rows reappear in the same slot.
- Reset mid-frame: the reset cycle drives columns off, and the scan restarts at column 0 with a BLANK phase. The first `frame_start` pulse comes one cycle after `reset_n` returns high.
- No two columns are ever active in the same cycle. At least BLANK all-off cycles separate any two different active columns.

## Structure
- Shared package `matrix_pkg`:
  - `N_COLS = 5`, `N_ROWS = 7`.
  - Column-mirror map function `mirror_sel(col_idx)`, returning the half-image index 2, 1, 0, 1, 2.
  - `COLS_OFF = 5'b11111`.
- Sub-module `tick_divider`: generic parameterised modulo counter with `clk`, `reset_n`, `enable`, `count`, `wrap`. It is instantiated for the prescaler and for the blink frame counter.
- Top level holds `col_idx`, the shadow registers, the blink toggle and the output registers.

## Test plan
- For all scenarios: CLK_DIV=4, BLANK=1, BLINK_FRAMES=2.
- Reset, then hold `col_2=7'h41`, `col_1=7'h22`, `col_0=7'h1C`.
  - First frame shows rows 0, because the shadow registers are still at reset value 0.
  - Second frame shows column 0 = 0x41, column 1 = 0x22, column 2 = 0x1C, column 3 = 0x22, column 4 = 0x41.
  - `matrix_cols` sequence: 11110, 11101, 11011, 10111, 01111.
- Every slot shows 1 cycle of `matrix_cols = 11111` with `matrix_rows = 0`, then 3 cycles driven. `frame_start` is high exactly once every 20 cycles.
- Change `col_0` from 0x1C to 0x7F in the middle of column 2's slot: the current frame still shows 0x1C, and 0x7F appears from the next frame's column 2.
- `blink_en = 1` from a frame boundary: 2 frames with rows lit, then 2 frames with rows 0 (columns still scan), then repeat. Drop `blink_en` during an off phase: rows return within 2 cycles.
- Assert `reset_n = 0` during column 3's DRIVE phase:
  - Next cycle: `matrix_cols = 11111`, `matrix_rows = 0`.
  - After release, scan restarts at column 0 and the shadow image is 0 for the first frame.
- Assertion, checked throughout: at most one zero in `matrix_cols` on every cycle.

Source files
------------

// File: rtl/matrix_pkg.sv
`default_nettype none
// +------------------------------------------------------------------+
// | matrix_pkg: shared geometry and column-mirror map for 5x7 matrix |
// | Rev 1.0                                                          |
// +------------------------------------------------------------------+
package matrix_pkg;

  localparam int N_COLS = 5;
  localparam int N_ROWS = 7;
  localparam logic [N_COLS-1:0] COLS_OFF = 5'b11111;

  typedef logic [N_ROWS-1:0] row_t;
  typedef logic [2:0]        col_idx_t;

  // Physical column -> half-image index (2,1,0,1,2): the image is Y-symmetric.
  function automatic logic [1:0] mirror_sel(input col_idx_t col_idx);
    case (col_idx)
      3'd0, 3'd4: mirror_sel = 2'd2;
      3'd1, 3'd3: mirror_sel = 2'd1;
      default:    mirror_sel = 2'd0;
    endcase
  endfunction

endpackage
`default_nettype wire

// File: rtl/tick_divider.sv
`default_nettype none
// +------------------------------------------------------------------+
// | tick_divider: modulo-MODULO counter with a terminal-count strobe  |
// | Rev 1.0                                                          |
// +------------------------------------------------------------------+
module tick_divider #(
  parameter int MODULO = 4,
  parameter int W      = (MODULO > 1) ? $clog2(MODULO) : 1
) (
  input  logic         clk,
  input  logic         reset_n,
  input  logic         enable,
  output logic [W-1:0] count,
  output logic         wrap
);

  localparam logic [W-1:0] LAST = W'(MODULO - 1);

  assign wrap = enable && (count == LAST);

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      count <= '0;
    end else if (enable) begin
      count <= wrap ? '0 : count + 1'b1;
    end
  end

endmodule
`default_nettype wire

// File: rtl/led_matrix_scanner.sv
`default_nettype none
// +------------------------------------------------------------------+
// | led_matrix_scanner: tear-free, anti-ghosting 5x7 column scanner  |
// | Rev 1.0                                                          |
// +------------------------------------------------------------------+
module led_matrix_scanner
  import matrix_pkg::*;
#(
  parameter int CLK_DIV      = 50000,
  parameter int BLANK        = 2,
  parameter int BLINK_FRAMES = 100
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic [N_ROWS-1:0] col_2,
  input  logic [N_ROWS-1:0] col_1,
  input  logic [N_ROWS-1:0] col_0,
  input  logic              blink_en,
  output logic [N_COLS-1:0] matrix_cols,
  output logic [N_ROWS-1:0] matrix_rows,
  output logic              frame_start
);

  localparam int DIV_W  = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam int BCNT_W = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;
  localparam logic [DIV_W-1:0]  BLANK_C   = DIV_W'(BLANK);
  localparam logic [BCNT_W-1:0] LAST_BCNT = BCNT_W'(BLINK_FRAMES - 1);
  localparam col_idx_t          LAST_COL  = 3'(N_COLS - 1);

  logic [DIV_W-1:0]  div;
  logic              div_wrap;
  logic [BCNT_W-1:0] bcnt;
  logic              bcnt_wrap;
  logic              frame_wrap;
  logic              blink_flip;
  logic              blink_on;
  col_idx_t          col_idx;
  row_t              sh2, sh1, sh0;
  row_t              sel_rows;
  logic [N_COLS-1:0] drive_cols;

  tick_divider #(.MODULO(CLK_DIV), .W(DIV_W)) u_prescaler (
    .clk     (clk),
    .reset_n (reset_n),
    .enable  (1'b1),
    .count   (div),
    .wrap    (div_wrap)
  );

  assign frame_wrap = div_wrap && (col_idx == LAST_COL);

  // Frame counter is held cleared while blinking is off, so enabling starts at 0.
  tick_divider #(.MODULO(BLINK_FRAMES), .W(BCNT_W)) u_blink_cnt (
    .clk     (clk),
    .reset_n (reset_n & blink_en),
    .enable  (frame_wrap),
    .count   (bcnt),
    .wrap    (bcnt_wrap)
  );

  assign blink_flip = bcnt_wrap && (bcnt == LAST_BCNT);
  assign drive_cols = ~(N_COLS'(1) << col_idx);

  always_comb begin
    case (mirror_sel(col_idx))
      2'd2:    sel_rows = sh2;
      2'd1:    sel_rows = sh1;
      default: sel_rows = sh0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      col_idx     <= '0;
      sh2         <= '0;
      sh1         <= '0;
      sh0         <= '0;
      blink_on    <= 1'b1;
      matrix_cols <= COLS_OFF;
      matrix_rows <= '0;
      frame_start <= 1'b0;
    end else begin
      if (div_wrap) begin
        col_idx <= frame_wrap ? '0 : col_idx + 3'd1;
      end

      // Image is captured only at the frame boundary so a frame never tears.
      if (frame_wrap) begin
        sh2 <= col_2;
        sh1 <= col_1;
        sh0 <= col_0;
      end

      if (!blink_en) begin
        blink_on <= 1'b1;
      end else if (blink_flip) begin
        blink_on <= ~blink_on;
      end

      if (div < BLANK_C) begin
        matrix_cols <= COLS_OFF;
        matrix_rows <= '0;
      end else begin
        matrix_cols <= drive_cols;
        matrix_rows <= sel_rows & {N_ROWS{blink_on}};
      end

      frame_start <= (col_idx == 3'd0) && (div == '0);
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_led_matrix_scanner.sv
`default_nettype none
// Directed bench for led_matrix_scanner with CLK_DIV=4, BLANK=1, BLINK_FRAMES=2.
module tb_led_matrix_scanner;

  typedef logic [6:0] img_t [5];

  localparam logic [4:0] COLS_OFF = 5'b11111;
  localparam logic [4:0] DRIVE_COLS [5] = '{5'b11110, 5'b11101, 5'b11011, 5'b10111, 5'b01111};

  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic [6:0] col_2 = 7'h00;
  logic [6:0] col_1 = 7'h00;
  logic [6:0] col_0 = 7'h00;
  logic       blink_en = 1'b0;
  logic [4:0] matrix_cols;
  logic [6:0] matrix_rows;
  logic       frame_start;

  int checks = 0;
  int errors = 0;

  img_t img_zero;
  img_t img_a;
  img_t img_b;

  led_matrix_scanner #(.CLK_DIV(4), .BLANK(1), .BLINK_FRAMES(2)) dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .col_2       (col_2),
    .col_1       (col_1),
    .col_0       (col_0),
    .blink_en    (blink_en),
    .matrix_cols (matrix_cols),
    .matrix_rows (matrix_rows),
    .frame_start (frame_start)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    checks++;
    if ($countones(~matrix_cols) > 1) begin
      errors++;
      $display("FAIL one_col_active: matrix_cols=%b, required at most one zero", matrix_cols);
    end
  end

  task automatic test_reset();
    col_2   = 7'h41;
    col_1   = 7'h22;
    col_0   = 7'h1C;
    reset_n = 1'b0;
    repeat (3) @(negedge clk);
    checks++;
    if (matrix_cols !== COLS_OFF) begin
      errors++;
      $display("FAIL reset_cols: got %b, required %b", matrix_cols, COLS_OFF);
    end
    checks++;
    if (matrix_rows !== 7'h00) begin
      errors++;
      $display("FAIL reset_rows: got %h, required 00", matrix_rows);
    end
    checks++;
    if (frame_start !== 1'b0) begin
      errors++;
      $display("FAIL reset_frame_start: got %b, required 0", frame_start);
    end
    reset_n = 1'b1;
  endtask

  // Frame 1 shows the cleared shadow image, frame 2 the latched inputs.
  task automatic test_scan();
    img_t img;
    logic [4:0] ec;
    logic [6:0] er;
    int fs_seen = 0;
    for (int f = 0; f < 2; f++) begin
      if (f == 0) img = img_zero;
      else        img = img_a;
      for (int k = 0; k < 20; k++) begin
        @(negedge clk);
        ec = (k % 4 == 0) ? COLS_OFF : DRIVE_COLS[k / 4];
        er = (k % 4 == 0) ? 7'h00 : img[k / 4];
        checks++;
        if (matrix_cols !== ec || matrix_rows !== er || frame_start !== (k == 0)) begin
          errors++;
          $display("FAIL scan f%0d k%0d: cols=%b rows=%h fs=%b, required cols=%b rows=%h fs=%b",
                   f, k, matrix_cols, matrix_rows, frame_start, ec, er, (k == 0));
        end
        if (frame_start === 1'b1) fs_seen++;
      end
    end
    checks++;
    if (fs_seen != 2) begin
      errors++;
      $display("FAIL frame_start_count: got %0d pulses in 40 cycles, required 2", fs_seen);
    end
  endtask

  task automatic test_mid_frame_update();
    img_t img;
    logic [4:0] ec;
    logic [6:0] er;
    for (int f = 0; f < 2; f++) begin
      if (f == 0) img = img_a;
      else        img = img_b;
      for (int k = 0; k < 20; k++) begin
        @(negedge clk);
        ec = (k % 4 == 0) ? COLS_OFF : DRIVE_COLS[k / 4];
        er = (k % 4 == 0) ? 7'h00 : img[k / 4];
        checks++;
        if (matrix_cols !== ec || matrix_rows !== er || frame_start !== (k == 0)) begin
          errors++;
          $display("FAIL update f%0d k%0d: cols=%b rows=%h fs=%b, required cols=%b rows=%h fs=%b",
                   f, k, matrix_cols, matrix_rows, frame_start, ec, er, (k == 0));
        end
        if (f == 0 && k == 9) col_0 = 7'h7F;
      end
    end
  endtask

  // Enabled at a frame boundary: on, on, off, off, on, on.
  task automatic test_blink();
    logic [4:0] ec;
    logic [6:0] er;
    logic lit;
    blink_en = 1'b1;
    for (int f = 0; f < 6; f++) begin
      lit = (f == 0 || f == 1 || f == 4 || f == 5);
      for (int k = 0; k < 20; k++) begin
        @(negedge clk);
        ec = (k % 4 == 0) ? COLS_OFF : DRIVE_COLS[k / 4];
        er = (k % 4 == 0 || !lit) ? 7'h00 : img_b[k / 4];
        checks++;
        if (matrix_cols !== ec || matrix_rows !== er || frame_start !== (k == 0)) begin
          errors++;
          $display("FAIL blink f%0d k%0d: cols=%b rows=%h fs=%b, required cols=%b rows=%h fs=%b",
                   f, k, matrix_cols, matrix_rows, frame_start, ec, er, (k == 0));
        end
      end
    end
  endtask

  // Off phase; blink_en drops after sample 5, rows come back at sample 7.
  task automatic test_blink_drop();
    logic [4:0] ec;
    logic [6:0] er;
    logic lit;
    for (int f = 0; f < 2; f++) begin
      for (int k = 0; k < 20; k++) begin
        @(negedge clk);
        lit = (f == 1) || (k >= 7);
        ec = (k % 4 == 0) ? COLS_OFF : DRIVE_COLS[k / 4];
        er = (k % 4 == 0 || !lit) ? 7'h00 : img_b[k / 4];
        checks++;
        if (matrix_cols !== ec || matrix_rows !== er || frame_start !== (k == 0)) begin
          errors++;
          $display("FAIL blink_drop f%0d k%0d: cols=%b rows=%h fs=%b, required cols=%b rows=%h fs=%b",
                   f, k, matrix_cols, matrix_rows, frame_start, ec, er, (k == 0));
        end
        if (f == 0 && k == 5) blink_en = 1'b0;
      end
    end
  endtask

  task automatic test_reset_mid_frame();
    img_t img;
    logic [4:0] ec;
    logic [6:0] er;
    for (int k = 0; k < 14; k++) begin
      @(negedge clk);
      ec = (k % 4 == 0) ? COLS_OFF : DRIVE_COLS[k / 4];
      er = (k % 4 == 0) ? 7'h00 : img_b[k / 4];
      checks++;
      if (matrix_cols !== ec || matrix_rows !== er || frame_start !== (k == 0)) begin
        errors++;
        $display("FAIL pre_reset k%0d: cols=%b rows=%h fs=%b, required cols=%b rows=%h fs=%b",
                 k, matrix_cols, matrix_rows, frame_start, ec, er, (k == 0));
      end
    end
    reset_n = 1'b0;
    @(negedge clk);
    checks++;
    if (matrix_cols !== COLS_OFF || matrix_rows !== 7'h00 || frame_start !== 1'b0) begin
      errors++;
      $display("FAIL mid_reset: cols=%b rows=%h fs=%b, required cols=11111 rows=00 fs=0",
               matrix_cols, matrix_rows, frame_start);
    end
    @(negedge clk);
    reset_n = 1'b1;
    for (int f = 0; f < 2; f++) begin
      if (f == 0) img = img_zero;
      else        img = img_b;
      for (int k = 0; k < 20; k++) begin
        @(negedge clk);
        ec = (k % 4 == 0) ? COLS_OFF : DRIVE_COLS[k / 4];
        er = (k % 4 == 0) ? 7'h00 : img[k / 4];
        checks++;
        if (matrix_cols !== ec || matrix_rows !== er || frame_start !== (k == 0)) begin
          errors++;
          $display("FAIL post_reset f%0d k%0d: cols=%b rows=%h fs=%b, required cols=%b rows=%h fs=%b",
                   f, k, matrix_cols, matrix_rows, frame_start, ec, er, (k == 0));
        end
      end
    end
  endtask

  initial begin
    img_zero = '{7'h00, 7'h00, 7'h00, 7'h00, 7'h00};
    img_a    = '{7'h41, 7'h22, 7'h1C, 7'h22, 7'h41};
    img_b    = '{7'h41, 7'h22, 7'h7F, 7'h22, 7'h41};
    test_reset();
    test_scan();
    test_mid_frame_update();
    test_blink();
    test_blink_drop();
    test_reset_mid_frame();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
